booth_mul_unit: RTL and testbench
=================================

// Module: booth_mul_unit
// PURPOSE
//   Multi-cycle signed Booth multiplier feeding the 64-bit Z register (ZHI/ZLO).
//   Replaces the single-cycle ALU multiply for CONTROL = 5'b00010. Operand A comes
//   from the Y register; operand B comes from the bus.
//   Start/done handshake lets the control sequencer stall T4 until the product is ready.
// PARAMETERS
//   WIDTH  32  operand width; must be even; product is 2*WIDTH bits
// PORTS
//   Clock      in   1        system clock, rising edge
//   Clear      in   1        asynchronous, active-low reset
//   start      in   1        begin a multiply; honoured only when busy=0
//   flush      in   1        synchronous abort; returns to IDLE, no done pulse
//   y_opnd     in   WIDTH    multiplicand A (Y register), signed
//   bus_opnd   in   WIDTH    multiplier B (bus), signed
//   busy       out  1        high while in RUN
//   done       out  1        one-cycle pulse; result_hi/lo valid from this cycle on
//   result_hi  out  WIDTH    product[2W-1:W], to ZHI
//   result_lo  out  WIDTH    product[W-1:0], to ZLO
// BEHAVIOUR
//   Reset (Clear=0): state=IDLE; busy=0, done=0, result_hi=0, result_lo=0, count=0.
//   FSM states (shared enum): IDLE -> RUN -> DONE -> IDLE.
//   - IDLE/DONE, start=1: latch A, B; set P = {(W+2)'b0, B, 1'b0}; count=0; go to RUN.
//     A start sampled in DONE is accepted; done still pulses for the prior op.
//   - RUN: one Booth step per cycle, N steps. Radix-2: N=WIDTH. Radix-4: N=WIDTH/2.
//     Radix-2 step, on P[1:0]: 01 add A, 10 sub A, 00/11 none, applied to the upper
//     field (W+2 bits, sign-extended). Then arithmetic shift right by 1.
//   - After step N: write result = P[2W:1] into result_hi/lo; go to DONE.
//   - DONE: done=1 for exactly one cycle; then IDLE unless start is accepted.
//   Latency: start sampled at edge k -> done high after edge k+N+1 (33 cycles at W=32, radix-2).
//   start while busy=1: ignored; latched operands unchanged.
//   flush: highest priority after reset; any state -> IDLE; results hold their old values.
//   Reset mid-RUN: immediate abort to reset values; no done pulse.
//   Results hold until the next completed op; operand inputs may change after start.
//   Arithmetic: two's complement throughout. The most-negative operand pair is exact:
//   0x80000000^2 = 0x4000000000000000. No overflow flag is produced.
// CONFIGURATION
//   BOOTH_RADIX4_EN defined: radix-4 recoding on P[2:0] selects 0, +-A, +-2A; shift by 2;
//     N = WIDTH/2 (done after 17 cycles at W=32). Upper field is W+2 bits to hold +-2A.
//   BOOTH_RADIX4_EN undefined: radix-2 as above. Results are bit-identical in both modes.
// STRUCTURE
//   Shared package (riscie_pkg) holds:
//     - FSM state enum {IDLE, RUN, DONE}
//     - ALU CONTROL code constant ALU_MUL = 5'b00010
//     - Booth select enum {BS_ZERO, BS_PA, BS_NA, BS_P2A, BS_N2A}
//   Sub-module booth_recoder: combinational; takes the low 2 or 3 bits of P and
//   emits the select. It is instantiated once.
//   Top level holds the FSM, the step counter ($clog2(WIDTH)+1 bits), P, and the adder.
// TESTING
//   1. Reset, then y=16, bus=32, pulse start -> done after 33 cycles; hi=0x0, lo=0x200.
//   2. y=-7, bus=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. y=-1, bus=-1 -> hi=0, lo=1.
//   3. y=bus=0x80000000 -> hi=0x40000000, lo=0x0. With BOOTH_RADIX4_EN, same value at 17 cycles.
//   4. Raise start again mid-RUN with new operands -> ignored; original product returned.
//   5. Clear low at RUN step 10 -> outputs 0 immediately; no done. flush mid-RUN -> IDLE,
//      previous result retained, no done.
//   6. Back-to-back: start held in the DONE cycle -> second op completes N+1 cycles later;
//      two done pulses total, each one cycle wide.

Source files
------------

// File: rtl/booth_mul_unit_pkg.sv
// Shared riscie package: FSM state encoding, ALU control code and Booth
// digit-select encoding for the multi-cycle multiplier.
// Build option: BOOTH_RADIX4_EN selects radix-4 recoding (3 bits per step,
// shift by 2). When it is undefined, radix-2 recoding is used (2 bits, shift by 1).
package riscie_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    localparam logic [4:0] ALU_MUL = 5'b00010;

    typedef enum logic [2:0] {BS_ZERO, BS_PA, BS_NA, BS_P2A, BS_N2A} booth_sel_t;

`ifdef BOOTH_RADIX4_EN
    localparam int BOOTH_BITS = 3;   // recoder window on P
    localparam int BOOTH_STEP = 2;   // bits retired per step
`else
    localparam int BOOTH_BITS = 2;
    localparam int BOOTH_STEP = 1;
`endif

endpackage

// File: rtl/booth_mul_unit_if.sv
// Handshake and operand/result bundle between the control sequencer (master)
// and the Booth multiplier (slave).
//   start, flush        : sequencer -> multiplier control
//   y_opnd, bus_opnd    : signed operands A (Y register) and B (bus)
//   busy, done          : multiplier status; done is a one-cycle pulse
//   result_hi/result_lo : product halves for ZHI/ZLO
interface booth_mul_unit_if #(parameter int WIDTH = 32) ();
    logic             start;
    logic             flush;
    logic [WIDTH-1:0] y_opnd;
    logic [WIDTH-1:0] bus_opnd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;

    modport master (output start, flush, y_opnd, bus_opnd,
                    input  busy, done, result_hi, result_lo);
    modport slave  (input  start, flush, y_opnd, bus_opnd,
                    output busy, done, result_hi, result_lo);
endinterface

// File: rtl/booth_mul_unit_recoder.sv
// Booth recoder: maps the low window of the partial-product register P to a
// digit select. The window is 2 bits (radix-2) or 3 bits (radix-4, enabled by
// BOOTH_RADIX4_EN).
//   i_bits : P[BOOTH_BITS-1:0]
//   o_sel  : digit select (0, +A, -A, +2A, -2A)
module booth_recoder
    import riscie_pkg::*;
(
    input  logic [BOOTH_BITS-1:0] i_bits,
    output booth_sel_t            o_sel
);

    always_comb begin
        o_sel = BS_ZERO;
`ifdef BOOTH_RADIX4_EN
        case (i_bits)
            3'b001, 3'b010: o_sel = BS_PA;
            3'b011:         o_sel = BS_P2A;
            3'b100:         o_sel = BS_N2A;
            3'b101, 3'b110: o_sel = BS_NA;
            default:        o_sel = BS_ZERO;
        endcase
`else
        case (i_bits)
            2'b01:   o_sel = BS_PA;
            2'b10:   o_sel = BS_NA;
            default: o_sel = BS_ZERO;
        endcase
`endif
    end

endmodule

// File: rtl/booth_mul_unit.sv
// Multi-cycle signed Booth multiplier for the Z register (ZHI/ZLO).
// Build option: BOOTH_RADIX4_EN halves the step count (radix-4 recoding).
// Ports:
//   Clock : system clock, rising edge
//   Clear : asynchronous active-low reset
//   mif   : slave side of booth_mul_unit_if (start/flush/operands in,
//           busy/done/result_hi/result_lo out)
// Latency from accepted start to done is N+1 cycles: N Booth steps plus one
// cycle to move P into the result registers.
module booth_mul_unit
    import riscie_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Clear,
    booth_mul_unit_if.slave  mif
);

    // P layout: {upper field (WIDTH+2), multiplier B (WIDTH), appended 0}
    localparam int PW = 2*WIDTH + 3;
    localparam int UW = WIDTH + 2;
    localparam int N  = WIDTH / BOOTH_STEP;
    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_t              r_state, w_state_nxt;
    logic [CW-1:0]           r_count;
    logic signed [WIDTH-1:0] r_a;
    logic [PW-1:0]           r_p;
    logic [WIDTH-1:0]        r_res_hi, r_res_lo;

    booth_sel_t              w_sel;
    logic signed [UW-1:0]    w_a_ext, w_addend, w_upper_sum;
    logic signed [PW-1:0]    w_p_cat, w_p_step;
    logic                    w_accept, w_last;

    booth_recoder u_recoder (
        .i_bits (r_p[BOOTH_BITS-1:0]),
        .o_sel  (w_sel)
    );

    assign w_accept = mif.start && !mif.flush && (r_state != RUN);
    // Extra RUN cycle after the N-th step transfers P into the result registers
    assign w_last   = (r_state == RUN) && (r_count == CW'(N));

    assign w_a_ext = {{2{r_a[WIDTH-1]}}, r_a};

    always_comb begin
        w_addend = '0;
        case (w_sel)
            BS_PA:   w_addend = w_a_ext;
            BS_NA:   w_addend = -w_a_ext;
            BS_P2A:  w_addend = w_a_ext <<< 1;
            BS_N2A:  w_addend = -(w_a_ext <<< 1);
            default: w_addend = '0;
        endcase
    end

    assign w_upper_sum = $signed(r_p[PW-1:WIDTH+1]) + w_addend;
    assign w_p_cat     = {w_upper_sum, r_p[WIDTH:0]};
    assign w_p_step    = w_p_cat >>> BOOTH_STEP;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (mif.start) w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = mif.start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (mif.flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (mif.flush || w_accept) begin
                r_count <= '0;
            end else if (r_state == RUN && !w_last) begin
                r_count <= r_count + 1'b1;
            end
            if (!mif.flush && w_last) begin
                r_res_hi <= r_p[2*WIDTH:WIDTH+1];
                r_res_lo <= r_p[WIDTH:1];
            end
        end
    end

    // Datapath registers: only meaningful between an accepted start and the result write
    always_ff @(posedge Clock) begin
        if (w_accept) begin
            r_a <= $signed(mif.y_opnd);
            r_p <= {{UW{1'b0}}, mif.bus_opnd, 1'b0};
        end else if (r_state == RUN && !w_last) begin
            r_p <= w_p_step;
        end
    end

    assign mif.busy      = (r_state == RUN);
    assign mif.done      = (r_state == DONE);
    assign mif.result_hi = r_res_hi;
    assign mif.result_lo = r_res_lo;

endmodule

// File: tb/tb_booth_mul_unit.sv
module tb_booth_mul_unit;
    import riscie_pkg::*;

    localparam int W = 32;
    localparam int N = W / BOOTH_STEP;
    localparam int LIMIT = 200;

    logic clk;
    logic clear_n;
    int   n_cmp;
    int   n_fail;
    logic [63:0] exp_q[$];

    booth_mul_unit_if #(.WIDTH(W)) mif ();

    booth_mul_unit #(.WIDTH(W)) dut (
        .Clock (clk),
        .Clear (clear_n),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return 64'(p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; cyc counts edges after the start-sampling edge.
    task automatic wait_done(output int cyc, output bit got);
        cyc = 0;
        got = 1'b0;
        while (cyc < LIMIT && !got) begin
            tick();
            cyc++;
            if (mif.done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic launch(input int a, input int b, input bit track);
        mif.y_opnd   = a;
        mif.bus_opnd = b;
        mif.start    = 1'b1;
        if (track) exp_q.push_back(model(a, b));
        tick();
        mif.start    = 1'b0;
        mif.y_opnd   = $urandom;
        mif.bus_opnd = $urandom;
    endtask

    task automatic run_op(input string name, input int a, input int b);
        int cyc;
        bit got;
        logic [63:0] e;
        launch(a, b, 1'b1);
        wait_done(cyc, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, LIMIT);
        end else begin
            if (cyc !== N + 1) begin
                n_fail++;
                $display("FAIL %s latency: got %0d want %0d", name, cyc, N + 1);
            end
            n_cmp++;
            if ({mif.result_hi, mif.result_lo} !== e) begin
                n_fail++;
                $display("FAIL %s product: got %h_%h want %h", name, mif.result_hi, mif.result_lo, e);
            end
            tick();
            n_cmp++;
            if (mif.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s done width: done=%b want 0 one cycle later", name, mif.done);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({mif.busy, mif.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset status: busy/done=%b want 00", {mif.busy, mif.done});
        end
        n_cmp++;
        if ({mif.result_hi, mif.result_lo} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset result: got %h_%h want 0", mif.result_hi, mif.result_lo);
        end
    endtask

    task automatic test_basic();
        run_op("y16xb32", 16, 32);
        n_cmp++;
        if ({mif.result_hi, mif.result_lo} !== 64'h0000_0000_0000_0200) begin
            n_fail++;
            $display("FAIL basic literal: got %h_%h want 0_200", mif.result_hi, mif.result_lo);
        end
        run_op("m7x3", -7, 3);
        n_cmp++;
        if ({mif.result_hi, mif.result_lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_fail++;
            $display("FAIL neg literal: got %h_%h want FFFFFFFF_FFFFFFEB", mif.result_hi, mif.result_lo);
        end
        run_op("m1xm1", -1, -1);
        run_op("5xm9", 5, -9);
        run_op("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        for (int i = 0; i < 4; i++) run_op("random", int'($urandom), int'($urandom));
    endtask

    task automatic test_min();
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000);
        n_cmp++;
        if ({mif.result_hi, mif.result_lo} !== 64'h4000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL min literal: got %h_%h want 40000000_00000000", mif.result_hi, mif.result_lo);
        end
        run_op("minxmax", 32'h8000_0000, 32'h7FFF_FFFF);
    endtask

    task automatic test_start_ignored();
        int cyc;
        bit got;
        logic [63:0] e;
        launch(1000, -3, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        mif.y_opnd   = 99;
        mif.bus_opnd = 77;
        mif.start    = 1'b1;
        tick();
        mif.start    = 1'b0;
        wait_done(cyc, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || (cyc + 6) !== N + 1) begin
            n_fail++;
            $display("FAIL ignore latency: got=%b cycles %0d want %0d", got, cyc + 6, N + 1);
        end
        n_cmp++;
        if ({mif.result_hi, mif.result_lo} !== e) begin
            n_fail++;
            $display("FAIL ignore product: got %h_%h want %h", mif.result_hi, mif.result_lo, e);
        end
        tick();
    endtask

    task automatic test_abort();
        int pulses;
        logic [63:0] prev;
        run_op("pre_abort", 123, -456);
        prev = model(123, -456);
        // asynchronous Clear in the middle of RUN
        launch(11, 13, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        #2;
        clear_n = 1'b0;
        #1;
        n_cmp++;
        if ({mif.busy, mif.done, mif.result_hi, mif.result_lo} !== 66'h0) begin
            n_fail++;
            $display("FAIL clear mid-run: busy=%b done=%b res=%h_%h want all 0",
                     mif.busy, mif.done, mif.result_hi, mif.result_lo);
        end
        tick();
        clear_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < N + 5; i++) begin
            tick();
            if (mif.done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL clear no-done: got %0d pulses want 0", pulses);
        end
        // synchronous flush in the middle of RUN
        run_op("pre_flush", 123, -456);
        launch(7, 8, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        mif.flush = 1'b1;
        tick();
        mif.flush = 1'b0;
        n_cmp++;
        if (mif.busy !== 1'b0 || {mif.result_hi, mif.result_lo} !== prev) begin
            n_fail++;
            $display("FAIL flush: busy=%b res=%h_%h want busy 0 res %h",
                     mif.busy, mif.result_hi, mif.result_lo, prev);
        end
        pulses = 0;
        for (int i = 0; i < N + 5; i++) begin
            tick();
            if (mif.done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL flush no-done: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int pulses;
        bit got;
        logic [63:0] e;
        launch(-25, 40, 1'b1);
        wait_done(cyc, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {mif.result_hi, mif.result_lo} !== e) begin
            n_fail++;
            $display("FAIL b2b first: got=%b res=%h_%h want %h", got, mif.result_hi, mif.result_lo, e);
        end
        pulses = got ? 1 : 0;
        // start held in the DONE cycle
        launch(-300, -700, 1'b1);
        n_cmp++;
        if (mif.done !== 1'b0 || mif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b restart: done=%b busy=%b want 0/1", mif.done, mif.busy);
        end
        wait_done(cyc, got);
        if (got) pulses++;
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || cyc !== N + 1 || {mif.result_hi, mif.result_lo} !== e) begin
            n_fail++;
            $display("FAIL b2b second: got=%b cycles %0d want %0d res %h_%h want %h",
                     got, cyc, N + 1, mif.result_hi, mif.result_lo, e);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (mif.done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 2) begin
            n_fail++;
            $display("FAIL b2b pulses: got %0d want 2", pulses);
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        clear_n      = 1'b0;
        mif.start    = 1'b0;
        mif.flush    = 1'b0;
        mif.y_opnd   = '0;
        mif.bus_opnd = '0;
        repeat (3) tick();
        test_reset();
        clear_n = 1'b1;
        tick();
        test_basic();
        test_min();
        test_start_ignored();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
